// File: rtl/qedmma_correlator_piso_axi_v2.sv
// Ping-pong correlator frame serializer onto an AXI-Stream master (indexed or dense packing).
// Define QEDMMA_PISO_HDR_EN to prefix each frame with a header beat (requires AXI_DATA_WIDTH >= 64).
module qedmma_correlator_piso_axi_v2 #(
  parameter int NUM_LANES      = 512,
  parameter int ACC_WIDTH      = 48,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int CNT_WIDTH      = 16,
  localparam int IDX_W         = $clog2(NUM_LANES),
  localparam int KEEP_W        = AXI_DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES*ACC_WIDTH-1:0] i_results_flat,
  input  logic                          i_results_valid,
  output logic                          o_results_ready,
  input  logic [IDX_W:0]                i_num_lanes,
  input  logic                          i_mode,
  output logic [AXI_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [KEEP_W-1:0]             m_axis_tkeep,
  output logic                          m_axis_tuser,
  output logic                          o_busy,
  output logic [IDX_W:0]                o_word_count,
  output logic [CNT_WIDTH-1:0]          o_frame_count,
  output logic [CNT_WIDTH-1:0]          o_drop_count
);
  localparam int LPW = AXI_DATA_WIDTH / ACC_WIDTH;
  localparam int BW  = IDX_W + 2;
`ifdef QEDMMA_PISO_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam logic [IDX_W:0] N_MAX = (IDX_W + 1)'(NUM_LANES);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t                    state_reg;
  logic [ACC_WIDTH-1:0]      buf_mem [2][NUM_LANES];
  logic [IDX_W:0]            n_reg [2];
  logic [1:0]                mode_reg;
  logic [1:0]                full_reg, full_next;
  logic                      wr_ptr_reg, rd_ptr_reg;
  logic [BW-1:0]             beat_reg, total_reg;
  logic [AXI_DATA_WIDTH-1:0] tdata_reg;
  logic                      tvalid_reg, tuser_reg, tlast_reg;
  logic [IDX_W:0]            word_count_reg;
  logic [CNT_WIDTH-1:0]      frame_count_reg, drop_count_reg;
  logic [31:0]               seq_reg;

  logic                      capture, handshake, frame_done, mode_cur;
  logic [IDX_W:0]            n_in, n_cur;
  logic [BW-1:0]             next_beat, total_cur;
  logic [31:0]               n_int, w_int, pay_w, lane_w;
  logic [AXI_DATA_WIDTH-1:0] beat_data;

  assign o_results_ready = !rst && !(full_reg[0] && full_reg[1]);
  assign capture         = i_results_valid && o_results_ready;
  assign handshake       = tvalid_reg && m_axis_tready;
  assign frame_done      = handshake && tlast_reg;
  assign n_in            = (i_num_lanes == '0 || i_num_lanes > N_MAX) ? N_MAX : i_num_lanes;
  assign n_cur           = n_reg[rd_ptr_reg];
  assign mode_cur        = mode_reg[rd_ptr_reg];
  assign next_beat       = (state_reg == LOAD) ? '0 : beat_reg + BW'(1);

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tuser  = tuser_reg;
  assign m_axis_tlast  = tlast_reg;
  assign m_axis_tkeep  = {KEEP_W{tvalid_reg}};
  assign o_busy        = (state_reg != IDLE) || (|full_reg);
  assign o_word_count  = word_count_reg;
  assign o_frame_count = frame_count_reg;
  assign o_drop_count  = drop_count_reg;

  always_comb begin
    n_int     = 32'(n_cur);
    w_int     = mode_cur ? (n_int + 32'(LPW) - 32'd1) / 32'(LPW) : n_int;
    total_cur = BW'(w_int + 32'(HDR));
  end

  // Content of the beat that will be presented next, taken from the read buffer.
  always_comb begin
    beat_data = '0;
    pay_w     = 32'(next_beat);
    lane_w    = '0;
`ifdef QEDMMA_PISO_HDR_EN
    if (next_beat == '0) begin
      beat_data[15:0]        = 16'hC0DE;
      beat_data[16]          = mode_cur;
      beat_data[17 +: IDX_W+1] = n_cur;
      beat_data[63:32]       = seq_reg;
    end else begin
      pay_w = pay_w - 32'd1;
`endif
      if (mode_cur) begin
        for (int j = 0; j < LPW; j++) begin
          lane_w = pay_w * 32'(LPW) + 32'(j);
          if (lane_w < n_int)
            beat_data[j*ACC_WIDTH +: ACC_WIDTH] = buf_mem[rd_ptr_reg][lane_w[IDX_W-1:0]];
        end
      end else if (pay_w < n_int) begin
        beat_data[ACC_WIDTH-1:0]      = buf_mem[rd_ptr_reg][pay_w[IDX_W-1:0]];
        beat_data[ACC_WIDTH +: IDX_W] = pay_w[IDX_W-1:0];
      end
`ifdef QEDMMA_PISO_HDR_EN
    end
`endif
  end

  // Capture and release touch different buffers, so both apply in the same cycle.
  always_comb begin
    full_next = full_reg;
    if (frame_done) full_next[rd_ptr_reg] = 1'b0;
    if (capture)    full_next[wr_ptr_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_LANES; i++)
        buf_mem[wr_ptr_reg][i] <= i_results_flat[i*ACC_WIDTH +: ACC_WIDTH];
      n_reg[wr_ptr_reg]    <= n_in;
      mode_reg[wr_ptr_reg] <= i_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      full_reg        <= '0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
      beat_reg        <= '0;
      total_reg       <= '0;
      tdata_reg       <= '0;
      tvalid_reg      <= 1'b0;
      tuser_reg       <= 1'b0;
      tlast_reg       <= 1'b0;
      word_count_reg  <= '0;
      frame_count_reg <= '0;
      drop_count_reg  <= '0;
      seq_reg         <= '0;
    end else begin
      full_reg <= full_next;
      if (capture) wr_ptr_reg <= !wr_ptr_reg;
      if (i_results_valid && !o_results_ready && drop_count_reg != '1)
        drop_count_reg <= drop_count_reg + CNT_WIDTH'(1);
      case (state_reg)
        IDLE: if (full_reg[rd_ptr_reg]) state_reg <= LOAD;
        LOAD: begin
          state_reg      <= STREAM;
          beat_reg       <= '0;
          total_reg      <= total_cur;
          tdata_reg      <= beat_data;
          tvalid_reg     <= 1'b1;
          tuser_reg      <= 1'b1;
          tlast_reg      <= (total_cur == BW'(1));
          word_count_reg <= '0;
        end
        STREAM: if (handshake) begin
          word_count_reg <= word_count_reg + (IDX_W + 1)'(1);
          if (tlast_reg) begin
            tvalid_reg      <= 1'b0;
            tuser_reg       <= 1'b0;
            tlast_reg       <= 1'b0;
            rd_ptr_reg      <= !rd_ptr_reg;
            frame_count_reg <= frame_count_reg + CNT_WIDTH'(1);
            seq_reg         <= seq_reg + 32'd1;
            state_reg       <= full_reg[!rd_ptr_reg] ? LOAD : IDLE;
          end else begin
            beat_reg  <= next_beat;
            tdata_reg <= beat_data;
            tuser_reg <= 1'b0;
            tlast_reg <= (next_beat == total_reg - BW'(1));
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qedmma_correlator_piso_axi_v2.sv
// Self-checking bench for qedmma_correlator_piso_axi_v2 (8 lanes x 48 bit, 128-bit stream).
`timescale 1ns/1ps
module tb_qedmma_correlator_piso_axi_v2;
  localparam int NL = 8, AW = 48, DW = 128, CW = 16, IW = 3, LPW = DW / AW;
`ifdef QEDMMA_PISO_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam logic [DW/8-1:0] KEEP_ALL = '1;

  logic clk = 1'b0;
  logic rst;
  logic [NL*AW-1:0] i_results_flat;
  logic i_results_valid, o_results_ready, i_mode;
  logic [IW:0] i_num_lanes, o_word_count;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser, o_busy;
  logic [DW/8-1:0] m_axis_tkeep;
  logic [CW-1:0] o_frame_count, o_drop_count;

  qedmma_correlator_piso_axi_v2 #(.NUM_LANES(NL), .ACC_WIDTH(AW), .AXI_DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_results_flat(i_results_flat), .i_results_valid(i_results_valid),
    .o_results_ready(o_results_ready), .i_num_lanes(i_num_lanes), .i_mode(i_mode),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .o_busy(o_busy), .o_word_count(o_word_count), .o_frame_count(o_frame_count),
    .o_drop_count(o_drop_count));

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic user; logic last; } beat_t;
  beat_t exp_q[$];
  logic [AW-1:0] lanes [NL];
  int n_checks = 0, n_pass = 0;
  int exp_frames = 0, exp_drops = 0, exp_words = 0;
  logic [31:0] exp_seq = '0;
  int cyc = 0, eof_cyc = 0, sof_gap = 0, hs_total = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Expected beats for one accepted frame, derived directly from the packing rules.
  task automatic push_frame(input int n_raw, input bit mode);
    int n, w;
    beat_t b;
    n = (n_raw == 0 || n_raw > NL) ? NL : n_raw;
    w = mode ? (n + LPW - 1) / LPW : n;
    if (HDR != 0) begin
      b.data = '0;
      b.data[15:0] = 16'hC0DE;
      b.data[16] = mode;
      b.data[17 +: IW+1] = (IW + 1)'(n);
      b.data[63:32] = exp_seq;
      b.user = 1'b1;
      b.last = 1'b0;
      exp_q.push_back(b);
      exp_seq++;
    end
    for (int k = 0; k < w; k++) begin
      b.data = '0;
      if (!mode) b.data = DW'(lanes[k]) | (DW'(k) << AW);
      else
        for (int j = 0; j < LPW; j++)
          if (k * LPW + j < n) b.data = b.data | (DW'(lanes[k*LPW+j]) << (AW * j));
      b.user = (HDR == 0 && k == 0);
      b.last = (k == w - 1);
      exp_q.push_back(b);
    end
    exp_frames++;
    exp_words = w + HDR;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < NL; i++) lanes[i] = rnd ? AW'({$urandom(), $urandom()}) : AW'(i + 1);
  endtask

  task automatic send(input int n_raw, input bit mode, input bit accept);
    for (int i = 0; i < NL; i++) i_results_flat[i*AW +: AW] = lanes[i];
    i_num_lanes = (IW + 1)'(n_raw);
    i_mode = mode;
    i_results_valid = 1'b1;
    if (accept) push_frame(n_raw, mode);
    else exp_drops++;
    tick();
    i_results_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && c < budget) begin
      tick();
      c++;
    end
    chk("drain_in_budget", DW'(c < budget), DW'(1));
  endtask

  // Stream monitor: handshakes are judged at the falling edge before the clock edge that takes them.
  logic [DW-1:0] prev_data;
  logic [1:0] prev_flags;
  bit prev_stall = 1'b0;
  beat_t got;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_tvalid", DW'(m_axis_tvalid), DW'(1));
        chk("stall_tdata", m_axis_tdata, prev_data);
        chk("stall_flags", DW'({m_axis_tuser, m_axis_tlast}), DW'(prev_flags));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_total++;
        chk("beat_expected", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("beat_tdata", m_axis_tdata, got.data);
          chk("beat_tuser", DW'(m_axis_tuser), DW'(got.user));
          chk("beat_tlast", DW'(m_axis_tlast), DW'(got.last));
          chk("beat_tkeep", DW'(m_axis_tkeep), DW'(KEEP_ALL));
        end
        if (m_axis_tuser) sof_gap = cyc - eof_cyc;
        if (m_axis_tlast) eof_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_flags = {m_axis_tuser, m_axis_tlast};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, base;
    rst = 1'b1; i_results_valid = 1'b0; i_results_flat = '0; i_num_lanes = '0; i_mode = 1'b0;
    m_axis_tready = 1'b1;
    fill(0);
    repeat (3) tick();
    chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_tdata", m_axis_tdata, DW'(0));
    chk("rst_tkeep", DW'(m_axis_tkeep), DW'(0));
    chk("rst_tuser_tlast", DW'({m_axis_tuser, m_axis_tlast}), DW'(0));
    chk("rst_ready", DW'(o_results_ready), DW'(0));
    chk("rst_busy", DW'(o_busy), DW'(0));
    chk("rst_counts", DW'({o_word_count, o_frame_count, o_drop_count}), DW'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_release", DW'(o_results_ready), DW'(1));
    tick();

    // Indexed, n=8, lanes i+1, with first-beat latency
    fill(0);
    send(8, 1'b0, 1'b1);
    chk("lat_n_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("busy_after_capture", DW'(o_busy), DW'(1));
    tick();
    chk("lat_n1_tvalid", DW'(m_axis_tvalid), DW'(0));
    tick();
    chk("lat_n2_tvalid", DW'(m_axis_tvalid), DW'(1));
    chk("lat_n2_tuser", DW'(m_axis_tuser), DW'(1));
    wait_drain(200);
    chk("idx_frame_count", DW'(o_frame_count), DW'(exp_frames));
    chk("idx_word_count", DW'(o_word_count), DW'(exp_words));
    chk("idle_busy", DW'(o_busy), DW'(0));

    // Dense, n=5
    fill(1);
    send(5, 1'b1, 1'b1);
    wait_drain(200);
    chk("dense_frame_count", DW'(o_frame_count), DW'(exp_frames));
    chk("dense_word_count", DW'(o_word_count), DW'(exp_words));

    // Back-to-back frames plus a third while both buffers are full
    fill(1); send(8, 1'b0, 1'b1);
    fill(1); send(3, 1'b1, 1'b1);
    chk("ready_both_full", DW'(o_results_ready), DW'(0));
    fill(1); send(6, 1'b0, 1'b0);
    chk("drop_count", DW'(o_drop_count), DW'(exp_drops));
    wait_drain(300);
    chk("bubble_gap", DW'(sof_gap), DW'(2));
    chk("b2b_frame_count", DW'(o_frame_count), DW'(exp_frames));

    // Random backpressure, random n (including 0 and 9) and mode
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      fill(1);
      c = 0;
      while (!o_results_ready && c < 500) begin tick(); c++; end
      chk("ready_wait", DW'(c < 500), DW'(1));
      send(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain(3000);
    rand_ready = 1'b0;
    tick();
    chk("rand_frame_count", DW'(o_frame_count), DW'(exp_frames));
    chk("rand_drop_count", DW'(o_drop_count), DW'(exp_drops));

    // Reset in the middle of a frame
    fill(0);
    send(8, 1'b0, 1'b1);
    base = hs_total;
    c = 0;
    while (hs_total < base + 3 && c < 100) begin tick(); c++; end
    chk("reach_beat3", DW'(c < 100), DW'(1));
    rst = 1'b1;
    tick();
    chk("abort_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("abort_counts", DW'({o_word_count, o_frame_count, o_drop_count}), DW'(0));
    chk("abort_ready", DW'(o_results_ready), DW'(0));
    exp_q.delete();
    exp_frames = 0; exp_drops = 0; exp_seq = '0;
    rst = 1'b0;
    #1;
    chk("abort_ready_release", DW'(o_results_ready), DW'(1));
    tick();
    fill(1);
    send(8, 1'b0, 1'b1);
    wait_drain(200);
    chk("post_rst_frame_count", DW'(o_frame_count), DW'(exp_frames));

    // Out-of-range lane counts fall back to all lanes
    fill(1); send(0, 1'b0, 1'b1);
    fill(1); send(9, 1'b0, 1'b1);
    wait_drain(300);
    chk("nclamp_frame_count", DW'(o_frame_count), DW'(exp_frames));
    chk("nclamp_word_count", DW'(o_word_count), DW'(exp_words));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/qedmma_correlator_piso_axi_v2.md
Name: qedmma_correlator_piso_axi_v2

Overview:
Parametrised, double-buffered successor serializer for correlator-bank results. It captures a parallel frame of NUM_LANES accumulators into one of two ping-pong buffers and streams it on an AXI-Stream master to the DMA. Each frame is packed in a runtime-selected mode (indexed or dense), with a runtime lane count. A second frame can be accepted while the first streams, and drop/frame statistics are exported.

Parameters:
NUM_LANES, 512, max accumulators per frame (≥2)
ACC_WIDTH, 48, bits per accumulator
AXI_DATA_WIDTH, 128, tdata width (multiple of 8; ≥ ACC_WIDTH+IDX_W, IDX_W=$clog2(NUM_LANES))
CNT_WIDTH, 16, width of frame/drop counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_results_flat  in  NUM_LANES*ACC_WIDTH  lane i at [i*ACC_WIDTH +: ACC_WIDTH]
i_results_valid  in  1  frame present (single-cycle qualifier)
o_results_ready  out  1  a buffer is free
i_num_lanes  in  IDX_W+1  lanes to send this frame; latched at capture
i_mode  in  1  0=indexed, 1=dense; latched at capture
m_axis_tdata  out  AXI_DATA_WIDTH  beat data
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  last beat of frame
m_axis_tkeep  out  AXI_DATA_WIDTH/8  byte enables
m_axis_tuser  out  1  first beat of frame (SOF)
o_busy  out  1  any buffer full or stream active
o_word_count  out  IDX_W+1  beats accepted in current frame
o_frame_count  out  CNT_WIDTH  frames completed (wraps)
o_drop_count  out  CNT_WIDTH  frames dropped (saturates at all-ones)

Behaviour:
- Reset (sync, rst=1 at edge): all outputs 0 except o_results_ready=0 during rst, 1 on the first cycle after release. Both buffers marked empty, FSM→IDLE. Buffer contents are not cleared. A mid-frame reset aborts the stream: tvalid=0 after that edge, no tlast is issued.
- Capture: i_results_valid && o_results_ready at edge N writes the flat input into the write buffer, marks it full, toggles the write pointer, and latches n = i_num_lanes and mode. n=0 or n>NUM_LANES is treated as NUM_LANES.
- Drop: i_results_valid && !o_results_ready → frame discarded, o_drop_count+1 (saturating).
- o_results_ready = at least one buffer empty, evaluated on registered state. A buffer freed by the tlast handshake at edge N is capturable from cycle N+1.
- FSM: IDLE→LOAD when the read buffer is full. LOAD (1 cycle) → STREAM.
- STREAM→LOAD on the tlast handshake if the other buffer is full, else →IDLE.
- First beat: tvalid=1 after edge N+2 (capture at N). Exactly one bubble cycle between back-to-back frames.
- Beats per frame: W = n in indexed mode; W = ceil(n/LPW) in dense mode, where LPW = AXI_DATA_WIDTH/ACC_WIDTH (integer).
- Indexed beat k: [ACC_WIDTH-1:0] = lane k; [ACC_WIDTH +: IDX_W] = k; upper bits 0.
- Dense beat k: slot j at [j*ACC_WIDTH +: ACC_WIDTH] = lane k*LPW+j. Slots past n-1 are zero-filled; the remaining high bits are 0.
- tkeep all-ones on every beat. tuser=1 on beat 0 only. tlast=1 on beat W-1 only; when W=1, both tuser and tlast are 1.
- AXI rules: tdata/tuser/tlast/tkeep are held stable while tvalid && !tready. tvalid is never deasserted without a handshake. Beats advance one per cycle while tready=1, with no internal bubbles.
- o_word_count increments per handshake, clears at frame start. o_frame_count+1 on the tlast handshake.
- o_busy = (state!=IDLE) || any buffer full.
- Capture and the tlast handshake in the same cycle are both honoured independently.

Optional Feature:
QEDMMA_PISO_HDR_EN:
- Defined: each frame is preceded by one header beat carrying tuser=1. Layout: [15:0]=0xC0DE, [16]=mode, [17 +: IDX_W+1]=n, [63:32]=32-bit frame sequence number (wraps, 0 after reset); other bits 0.
- Payload beats then carry tuser=0. Beats per frame = W+1, and o_word_count includes the header. First-beat latency is unchanged; the header is the first beat.
- Undefined: no header, behaviour exactly as above.

Test Plan:
NUM_LANES=8, AXI=128, indexed, n=8, lane i=i+1, tready=1 → 8 beats 2 cycles after capture; beat 3 = {0…, idx 3, 48'd4}; tuser on beat 0, tlast on beat 7; o_frame_count=1.
Dense, n=5, LPW=2 → 3 beats; beat 2 slot0=lane4 value, slot1=0; tlast on beat 2.
Two frames on consecutive cycles plus a third while both buffers full → frames 1 and 2 streamed with 1 bubble between them; o_drop_count=1.
Random tready (≈50% duty) → tdata stable while stalled, no lost or duplicate beats, order intact.
rst pulsed at beat 3 of 8 → tvalid=0 next cycle, counters 0; a new frame after release streams from beat 0 with SOF.
n=0 and n=9 (NUM_LANES=8) → both send 8 beats; with QEDMMA_PISO_HDR_EN the header reads n=8, and the sequence number increments 0,1 across two frames.
